// File: rtl/mem_byte_ctrl_if.sv
// Bus bundle between the byte memory controller, its two requesters (IF, LSB) and the RAM/IO port.
// slave = controller view, master = requester/RAM view.
interface mem_byte_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [7:0]        if_data;

    logic              ls_req;
    logic              ls_wr;
    logic [ADDR_W-1:0] ls_addr;
    logic [7:0]        ls_wdata;
    logic              ls_valid;
    logic [7:0]        ls_rdata;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic              io_buffer_full;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_addr, ls_wdata, ram_din, io_buffer_full,
        output if_valid, if_data, ls_valid, ls_rdata, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_addr, ls_wdata, ram_din, io_buffer_full,
        input  if_valid, if_data, ls_valid, ls_rdata, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Byte-serial memory controller: arbitrates IF reads and LSB reads/writes onto one RAM/IO bus.
// Optional MEM_BYTE_CTRL_RR_EN selects round-robin arbitration; default is fixed LS-over-IF priority.
module mem_byte_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    mem_byte_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                port_ls_q, port_ls_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic [DATA_W-1:0]   ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic                ls_valid_q, ls_valid_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

    logic                io_blocked_c;
    logic                ls_elig_c;
    logic                grant_ls_c;
    logic                grant_if_c;

    // An IO write cannot be taken while the IO output buffer is full.
    assign io_blocked_c = bus.ls_wr && (bus.ls_addr[17:16] == 2'b11) && bus.io_buffer_full;
    assign ls_elig_c    = bus.ls_req && !io_blocked_c;

`ifdef MEM_BYTE_CTRL_RR_EN
    logic last_ls_q, last_ls_d;

    // On a tie, the port not granted last time wins.
    always_comb begin
        grant_ls_c = ls_elig_c && !(bus.if_req && last_ls_q);
        last_ls_d  = last_ls_q;
        if (state_q == S_IDLE && (grant_ls_c || grant_if_c)) begin
            last_ls_d = grant_ls_c;
        end
    end
`else
    always_comb begin
        grant_ls_c = ls_elig_c;
    end
`endif

    assign grant_if_c = bus.if_req && !grant_ls_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_ls_d  = port_ls_q;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = ram_wr_q;
        if_valid_d = if_valid_q;
        if_data_d  = if_data_q;
        ls_valid_d = ls_valid_q;
        ls_rdata_d = ls_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ls_c) begin
                    port_ls_d  = 1'b1;
                    ram_a_d    = bus.ls_addr;
                    ram_dout_d = bus.ls_wdata;
                    ram_wr_d   = bus.ls_wr;
                    state_d    = S_ISSUE;
                end else if (grant_if_c) begin
                    port_ls_d  = 1'b0;
                    ram_a_d    = bus.if_addr;
                    ram_wr_d   = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_wr_d = 1'b0;
                if (ram_wr_q) begin
                    ls_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    cnt_d   = CNT_W'(RAM_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (port_ls_q) begin
                        ls_rdata_d = bus.ram_din;
                        ls_valid_d = 1'b1;
                    end else begin
                        if_data_d  = bus.ram_din;
                        if_valid_d = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if_valid_d = 1'b0;
                ls_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rdy_in low freezes every register, valid pulses included.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            port_ls_q  <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_data_q  <= '0;
            ls_valid_q <= 1'b0;
            ls_rdata_q <= '0;
`ifdef MEM_BYTE_CTRL_RR_EN
            last_ls_q  <= 1'b0;
`endif
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_ls_q  <= port_ls_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            if_valid_q <= if_valid_d;
            if_data_q  <= if_data_d;
            ls_valid_q <= ls_valid_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_BYTE_CTRL_RR_EN
            last_ls_q  <= last_ls_d;
`endif
        end
    end

    assign bus.ram_a    = ram_a_q;
    assign bus.ram_dout = ram_dout_q;
    assign bus.ram_wr   = ram_wr_q;
    assign bus.if_valid = if_valid_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_valid = ls_valid_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Self-checking bench for mem_byte_ctrl: RAM/IO model, directed scenarios and random transactions
// compared against a byte-addressed reference memory.
module tb_mem_byte_ctrl;
    localparam int unsigned RAM_LAT = 1;

    logic clk;
    logic rst_n;
    logic rdy;

    int n_cmp;
    int n_fail;
    int wr_pulses;
    int overlap_cnt;

    mem_byte_ctrl_if #(.ADDR_W(32)) bus ();

    mem_byte_ctrl #(.ADDR_W(32), .RAM_LAT(RAM_LAT)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    // RAM/IO model: one-cycle synchronous read, IO writes logged instead of stored
    logic [7:0]  mem     [0:65535];
    bit          written [0:65535];
    logic [39:0] io_log  [$];

    always @(posedge clk) begin
        if (bus.ram_wr) begin
            wr_pulses <= wr_pulses + 1;
            if (bus.ram_a[17:16] == 2'b11) begin
                io_log.push_back({bus.ram_a, bus.ram_dout});
            end else begin
                mem[bus.ram_a[15:0]]     <= bus.ram_dout;
                written[bus.ram_a[15:0]] <= 1'b1;
            end
        end
        bus.ram_din <= written[bus.ram_a[15:0]] ? mem[bus.ram_a[15:0]] : init_byte(bus.ram_a[15:0]);
    end

    always @(negedge clk) begin
        if (bus.if_valid && bus.ls_valid) overlap_cnt <= overlap_cnt + 1;
    end

    // Reference memory: what every plain address should hold
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a[15:0])) return ref_mem[a[15:0]];
        return init_byte(a[15:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction issued from IDLE; returns in the following IDLE cycle
    task automatic xact(input bit is_ls, input bit wr, input logic [31:0] addr, input logic [7:0] wd);
        int   lat;
        bit   seen;
        logic [7:0] exp_d;
        lat   = wr ? 2 : 2 + int'(RAM_LAT);
        exp_d = ref_rd(addr);
        seen  = 1'b0;
        if (is_ls) begin
            bus.ls_req = 1'b1; bus.ls_wr = wr; bus.ls_addr = addr; bus.ls_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int k = 1; k <= 12 && !seen; k++) begin
            tick();
            if (k == 1) begin
                bus.ls_req = 1'b0;
                bus.if_req = 1'b0;
                check("issue_ram_a", bus.ram_a, addr);
                check("issue_ram_wr", 32'(bus.ram_wr), 32'(wr));
                if (wr) check("issue_ram_dout", 32'(bus.ram_dout), 32'(wd));
            end
            if (is_ls ? bus.ls_valid : bus.if_valid) begin
                seen = 1'b1;
                check("latency", 32'(k), 32'(lat));
                if (!wr) check(is_ls ? "ls_rdata" : "if_data",
                               32'(is_ls ? bus.ls_rdata : bus.if_data), 32'(exp_d));
            end
        end
        check("valid_seen", 32'(seen), 32'd1);
        if (wr) ref_mem[addr[15:0]] = wd;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int         pc [5];
        bit         pp [5];
        logic [7:0] pd [5];
        int         np;
        int         k;
        int         wr0;
        int         vcnt;
        bit         if_seen;
        logic [39:0] io_e;

        n_cmp = 0; n_fail = 0; wr_pulses = 0; overlap_cnt = 0;
        rst_n = 1'b0; rdy = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.io_buffer_full = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_ls_valid", 32'(bus.ls_valid), 32'd0);
        check("rst_ram_wr",   32'(bus.ram_wr),   32'd0);
        check("rst_ram_a",    bus.ram_a,         32'd0);
        check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        check("rst_if_data",  32'(bus.if_data),  32'd0);
        check("rst_ls_rdata", 32'(bus.ls_rdata), 32'd0);
        rst_n = 1'b1;
        tick();

        // IF read of preset byte, then LS write and read-back
        check("preset_0x1000", 32'(ref_rd(32'h1000)), 32'h0000_00A5);
        xact(1'b0, 1'b0, 32'h1000, 8'h00);
        xact(1'b1, 1'b1, 32'h20, 8'h3C);
        xact(1'b1, 1'b0, 32'h20, 8'h00);
        xact(1'b0, 1'b0, 32'h20, 8'h00);
        check("readback_0x20", 32'(ref_rd(32'h20)), 32'h3C);

        // Contention from a fresh reset: both held, LS dropped after 4th valid, IF after 5th
        do_reset();
        np = 0;
        bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_addr = 32'h0300;
        bus.if_req = 1'b1; bus.if_addr = 32'h0400;
        for (k = 1; k <= 30 && np < 5; k++) begin
            tick();
            if (bus.ls_valid || bus.if_valid) begin
                pc[np] = k;
                pp[np] = bus.ls_valid;
                pd[np] = bus.ls_valid ? bus.ls_rdata : bus.if_data;
                np++;
                if (np == 4) bus.ls_req = 1'b0;
                if (np == 5) bus.if_req = 1'b0;
            end
        end
        check("cont_pulses", 32'(np), 32'd5);
        for (int i = 0; i < np; i++) begin
            bit exp_ls;
`ifdef MEM_BYTE_CTRL_RR_EN
            exp_ls = (i < 4) && (i % 2 == 0);
`else
            exp_ls = (i < 4);
`endif
            check("cont_cycle", 32'(pc[i]), 32'(3 + 4 * i));
            check("cont_port",  32'(pp[i]), 32'(exp_ls));
            check("cont_data",  32'(pd[i]), 32'(ref_rd(exp_ls ? 32'h0300 : 32'h0400)));
        end
        tick();

        // IO write blocked by full buffer; IF served meanwhile
        wr0 = wr_pulses;
        if_seen = 1'b0;
        bus.io_buffer_full = 1'b1;
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 8'h5A;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        vcnt = 0;
        for (k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.if_req = 1'b0;
            if (bus.if_valid) begin
                if_seen = 1'b1;
                check("io_if_cycle", 32'(k), 32'd3);
                check("io_if_data",  32'(bus.if_data), 32'(ref_rd(32'h0)));
            end
            if (bus.ls_valid) vcnt++;
        end
        check("io_if_seen", 32'(if_seen), 32'd1);
        check("io_blocked_wr", 32'(wr_pulses - wr0), 32'd0);
        check("io_blocked_lsv", 32'(vcnt), 32'd0);
        bus.io_buffer_full = 1'b0;
        for (k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                bus.ls_req = 1'b0;
                check("io_ram_wr", 32'(bus.ram_wr), 32'd1);
                check("io_ram_a",  bus.ram_a, 32'h0003_0000);
            end
            if (k == 2) check("io_ls_valid", 32'(bus.ls_valid), 32'd1);
        end
        check("io_wr_once", 32'(wr_pulses - wr0), 32'd1);
        check("io_log_size", 32'(io_log.size()), 32'd1);
        if (io_log.size() > 0) begin
            io_e = io_log[0];
            check("io_log_entry", 32'(io_e[7:0]), 32'h5A);
        end

        // Freeze during WAIT for 5 cycles delays the IF valid by 5
        if_seen = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0500;
        for (k = 1; k <= 15 && !if_seen; k++) begin
            tick();
            if (k == 1) bus.if_req = 1'b0;
            rdy = (k >= 2 && k < 7) ? 1'b0 : 1'b1;
            if (bus.if_valid) begin
                if_seen = 1'b1;
                check("frz_cycle", 32'(k), 32'd8);
                check("frz_data",  32'(bus.if_data), 32'(ref_rd(32'h0500)));
            end
        end
        check("frz_seen", 32'(if_seen), 32'd1);
        rdy = 1'b1;
        tick();

        // Freeze while a write valid is up: the pulse is held
        vcnt = 0;
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_addr = 32'h0600; bus.ls_wdata = 8'h11;
        for (k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) bus.ls_req = 1'b0;
            rdy = (k >= 2 && k < 5) ? 1'b0 : 1'b1;
            if (bus.ls_valid) vcnt++;
        end
        check("frz_valid_len", 32'(vcnt), 32'd4);
        ref_mem[16'h0600] = 8'h11;
        rdy = 1'b1;

        // Reset asserted during a write ISSUE cycle abandons it
        wr0 = wr_pulses;
        vcnt = 0;
        bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_addr = 32'h0040; bus.ls_wdata = 8'h77;
        tick();
        bus.ls_req = 1'b0;
        check("rstw_issue", 32'(bus.ram_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_ram_wr", 32'(bus.ram_wr), 32'd0);
        check("rstw_ram_a",  bus.ram_a, 32'd0);
        #3 rst_n = 1'b1;
        for (k = 1; k <= 5; k++) begin
            tick();
            if (bus.ls_valid) vcnt++;
        end
        check("rstw_no_valid", 32'(vcnt), 32'd0);
        check("rstw_no_write", 32'(wr_pulses - wr0), 32'd0);
        xact(1'b1, 1'b0, 32'h0040, 8'h00);
        xact(1'b0, 1'b0, 32'h0600, 8'h00);

        // Random single transactions on a small address pool
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a  = 32'h0200 + 32'($urandom_range(0, 15));
            case (op)
                0:       xact(1'b0, 1'b0, a, 8'h00);
                1:       xact(1'b1, 1'b0, a, 8'h00);
                default: xact(1'b1, 1'b1, a, 8'($urandom));
            endcase
        end

        check("valid_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
